// File: rtl/rpsc_annunciator.sv
// rtl/rpsc_annunciator.sv - RPSC fault annunciator: debounce, trip latch, first-out, lamps, horn, PAMP interlock
module rpsc_annunciator #(
    parameter int N_CH         = 8,
    parameter int DEBOUNCE_CYC = 16,
    parameter int FLASH_HALF   = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_ff_out,
    input  logic            i_ack,
    input  logic            i_clear,
    input  logic            i_lamp_test,
    output logic [N_CH-1:0] o_lamp,
    output logic [N_CH-1:0] o_first_out,
    output logic            o_horn,
    output logic            o_alarm_active,
    output logic            o_pamp_interlock
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_UNACK  = 2'd1;
    localparam logic [1:0] ST_ACKED  = 2'd2;

    logic [N_CH-1:0] ff_s1, ff_s2;
    logic [2:0]      ctl_s1, ctl_s2, ctl_d;
    logic [N_CH-1:0] filt, filt_d;
    logic [CW-1:0]   db_cnt [N_CH];
    logic [N_CH-1:0] trip_latch, ack;
    logic [N_CH-1:0] first_out;
    logic [1:0]      state;
    logic [FW-1:0]   flash_cnt;
    logic            flash_phase;

    logic            ack_edge, clear_edge;
    logic [N_CH-1:0] set_mask, clr_mask, latch_nxt, ack_nxt, lowest_set, lamp_nxt;
    logic [1:0]      state_nxt;

    // Two-flop synchronizers for the trip lines and the operator controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_s1  <= '0;
            ff_s2  <= '0;
            ctl_s1 <= '0;
            ctl_s2 <= '0;
            ctl_d  <= '0;
        end else begin
            ff_s1  <= i_ff_out;
            ff_s2  <= ff_s1;
            ctl_s1 <= {i_lamp_test, i_clear, i_ack};
            ctl_s2 <= ctl_s1;
            ctl_d  <= ctl_s2;
        end
    end

    // Per-channel debounce: filtered value follows only after DEBOUNCE_CYC steady differing cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
        end else begin
            filt_d <= filt;
            for (int i = 0; i < N_CH; i++) begin
                if (ff_s2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    filt[i]   <= ff_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state latch/ack bits; an ack edge swallows a coincident clear edge
    always_comb begin
        ack_edge   = ctl_s2[0] & ~ctl_d[0];
        clear_edge = ctl_s2[1] & ~ctl_d[1] & ~ack_edge;
        set_mask   = filt & ~filt_d & ~ack;
        clr_mask   = clear_edge ? (ack & ~filt) : '0;
        latch_nxt  = (trip_latch & ~clr_mask) | set_mask;
        if (ack_edge) ack_nxt = ack | trip_latch;
        else          ack_nxt = ack & ~clr_mask;
        if (latch_nxt == '0)                 state_nxt = ST_NORMAL;
        else if ((latch_nxt & ~ack_nxt) != '0) state_nxt = ST_UNACK;
        else                                 state_nxt = ST_ACKED;
        lowest_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (set_mask[i]) lowest_set = N_CH'(1) << i;
        end
    end

    // Trip latches, ack bits, FSM and first-out register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trip_latch <= '0;
            ack        <= '0;
            state      <= ST_NORMAL;
            first_out  <= '0;
        end else begin
            trip_latch <= latch_nxt;
            ack        <= ack_nxt;
            state      <= state_nxt;
            if (trip_latch == '0 && set_mask != '0)
                first_out <= lowest_set;
            else if ((first_out & latch_nxt) == '0)
                first_out <= '0;
        end
    end

    // Free-running flash generator; phase starts high out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b1;
        end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
            flash_cnt   <= '0;
            flash_phase <= ~flash_phase;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end

    // Lamp drive: test forces on, unacked flashes, acked steady
    always_comb begin
        if (ctl_s2[2]) lamp_nxt = '1;
        else           lamp_nxt = (trip_latch & ~ack & {N_CH{flash_phase}}) | (trip_latch & ack);
    end

    // Registered operator-facing outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_lamp           <= '0;
            o_first_out      <= '0;
            o_horn           <= 1'b0;
            o_alarm_active   <= 1'b0;
            o_pamp_interlock <= 1'b0;
        end else begin
            o_lamp           <= lamp_nxt;
            o_first_out      <= first_out;
            o_horn           <= (state == ST_UNACK);
            o_alarm_active   <= |trip_latch;
            o_pamp_interlock <= (|trip_latch) | (|filt);
        end
    end

endmodule
